// File: rtl/fifo_arb_rx.sv
// Packet router: parses a command word plus N payload words from one write
// stream and steers the whole packet into one of two FWFT output FIFOs.

module fifo_arb_rx_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop on the same edge frees the slot, so a push into a full FIFO is safe
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end
endmodule

// state | meaning
// CMD   | next accepted word is a command; route and length decoded from it
// DATA  | payload words pending; routed to latched target until remaining hits 0
module fifo_arb_rx #(
  parameter int            DW        = 32,
  parameter int            DEPTH     = 16,
  parameter logic [DW-1:0] SEL_MASK  = 1,
  parameter int            CNT_SHIFT = 1,
  parameter int            CNT_MASK  = 7
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          full_o,
  input  logic          f1_rd_en_i,
  output logic [DW-1:0] f1_rd_data_o,
  output logic          f1_empty_o,
  input  logic          f2_rd_en_i,
  output logic [DW-1:0] f2_rd_data_o,
  output logic          f2_empty_o
);
  typedef enum logic {ST_CMD, ST_DATA} state_t;

  localparam logic [DW-1:0] CNT_MASK_W = DW'(CNT_MASK);

  state_t        state, state_nxt;
  logic [3:0]    remaining, remaining_nxt;
  logic          target, target_nxt;
  logic [DW-1:0] field;
  logic [3:0]    n_cmd;
  logic          sel_cmd;
  logic          route_f1;
  logic          accept;
  logic          f1_full, f2_full;

  assign field   = (wr_data_i >> CNT_SHIFT) & CNT_MASK_W;
  assign sel_cmd = |(wr_data_i & SEL_MASK);

  always_comb begin
    n_cmd = 4'd0;
    if      (field == DW'(1)) n_cmd = 4'd1;
    else if (field == DW'(2)) n_cmd = 4'd2;
    else if (field == DW'(3)) n_cmd = 4'd4;
    else if (field == DW'(4)) n_cmd = 4'd8;
  end

  // back-pressure depends on state only, never on the word being presented
  assign full_o   = (state == ST_CMD) ? (f1_full || f2_full)
                                      : (target ? f1_full : f2_full);
  assign accept   = wr_en_i && !full_o;
  assign route_f1 = (state == ST_CMD) ? sel_cmd : target;

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    target_nxt    = target;
    if (accept) begin
      case (state)
        ST_CMD: begin
          if (n_cmd != 4'd0) begin
            target_nxt    = sel_cmd;
            remaining_nxt = n_cmd;
            state_nxt     = ST_DATA;
          end
        end
        ST_DATA: begin
          remaining_nxt = remaining - 4'd1;
          if (remaining == 4'd1) state_nxt = ST_CMD;
        end
        default: state_nxt = ST_CMD;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_CMD;
      remaining <= 4'd0;
      target    <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      target    <= target_nxt;
    end
  end

  fifo_arb_rx_fifo #(.DW(DW), .DEPTH(DEPTH)) u_f1 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (accept && route_f1),
    .push_data (wr_data_i),
    .pop       (f1_rd_en_i),
    .head      (f1_rd_data_o),
    .empty     (f1_empty_o),
    .full      (f1_full)
  );

  fifo_arb_rx_fifo #(.DW(DW), .DEPTH(DEPTH)) u_f2 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (accept && !route_f1),
    .push_data (wr_data_i),
    .pop       (f2_rd_en_i),
    .head      (f2_rd_data_o),
    .empty     (f2_empty_o),
    .full      (f2_full)
  );
endmodule

// File: tb/tb_fifo_arb_rx.sv
// Directed bench for fifo_arb_rx: packet routing, length decode, back-pressure
// and mid-packet reset, with hand-computed expected words.

module tb_fifo_arb_rx;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wr_en_i;
  logic [31:0] wr_data_i;
  logic        full_o;
  logic        f1_rd_en_i, f1_empty_o;
  logic [31:0] f1_rd_data_o;
  logic        f2_rd_en_i, f2_empty_o;
  logic [31:0] f2_rd_data_o;

  int vecs = 0;
  int errs = 0;

  always #5 clk_i = ~clk_i;

  fifo_arb_rx dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_en_i      (wr_en_i),
    .wr_data_i    (wr_data_i),
    .full_o       (full_o),
    .f1_rd_en_i   (f1_rd_en_i),
    .f1_rd_data_o (f1_rd_data_o),
    .f1_empty_o   (f1_empty_o),
    .f2_rd_en_i   (f2_rd_en_i),
    .f2_rd_data_o (f2_rd_data_o),
    .f2_empty_o   (f2_empty_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one write strobe across a single rising edge; inputs change #1 after edges
  task automatic wr(input logic [31:0] w);
    wr_en_i   = 1'b1;
    wr_data_i = w;
    @(posedge clk_i); #1;
    wr_en_i   = 1'b0;
  endtask

  task automatic pop(input int f, input logic [31:0] exp, input string tag);
    if (f == 1) begin
      chk({tag, "_f1_nonempty"}, {31'd0, f1_empty_o}, 32'd0);
      chk({tag, "_f1_data"}, f1_rd_data_o, exp);
      f1_rd_en_i = 1'b1;
    end else begin
      chk({tag, "_f2_nonempty"}, {31'd0, f2_empty_o}, 32'd0);
      chk({tag, "_f2_data"}, f2_rd_data_o, exp);
      f2_rd_en_i = 1'b1;
    end
    @(posedge clk_i); #1;
    f1_rd_en_i = 1'b0;
    f2_rd_en_i = 1'b0;
  endtask

  initial begin
    rst_ni     = 1'b0;
    wr_en_i    = 1'b0;
    wr_data_i  = '0;
    f1_rd_en_i = 1'b0;
    f2_rd_en_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_f1_empty", {31'd0, f1_empty_o}, 32'd1);
    chk("rst_f2_empty", {31'd0, f2_empty_o}, 32'd1);
    chk("rst_full", {31'd0, full_o}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // cmd 0x5: FIFO1, f=2 -> two payload words
    wr(32'h5); wr(32'hA); wr(32'hB);
    chk("p1_f2_empty", {31'd0, f2_empty_o}, 32'd1);
    pop(1, 32'h5, "p1_w0");
    pop(1, 32'hA, "p1_w1");
    pop(1, 32'hB, "p1_w2");
    chk("p1_f1_drained", {31'd0, f1_empty_o}, 32'd1);

    // cmd 0x0 (N=0) then cmd 0x6 (f=3 -> N=4), all to FIFO2
    wr(32'h0); wr(32'h6);
    wr(32'h10); wr(32'h11); wr(32'h13); wr(32'h15);
    chk("p2_f1_empty", {31'd0, f1_empty_o}, 32'd1);
    pop(2, 32'h0,  "p2_w0");
    pop(2, 32'h6,  "p2_w1");
    pop(2, 32'h10, "p2_w2");
    pop(2, 32'h11, "p2_w3");
    pop(2, 32'h13, "p2_w4");
    pop(2, 32'h15, "p2_w5");
    chk("p2_f2_drained", {31'd0, f2_empty_o}, 32'd1);

    // cmd 0x9 (f=4 -> N=8) to FIFO1, then 0x0 must parse as a command to FIFO2
    wr(32'h9);
    for (int i = 0; i < 8; i++) wr(32'h100 + 32'(i));
    wr(32'h0);
    pop(2, 32'h0, "p3_next_cmd");
    pop(1, 32'h9, "p3_cmd");
    for (int i = 0; i < 8; i++) pop(1, 32'h100 + 32'(i), $sformatf("p3_pl%0d", i));
    chk("p3_f1_drained", {31'd0, f1_empty_o}, 32'd1);

    // cmd 0xB: f=5 decodes to N=0, so the following 0x0 is a new command
    wr(32'hB); wr(32'h0);
    pop(1, 32'hB, "p4_cmd");
    chk("p4_f1_only_cmd", {31'd0, f1_empty_o}, 32'd1);
    pop(2, 32'h0, "p4_next_cmd");

    // fill FIFO1 with sixteen N=0 commands (bit0 set, f=0)
    for (int i = 0; i < 16; i++) wr((32'(i) << 4) | 32'h1);
    chk("p5_full_set", {31'd0, full_o}, 32'd1);
    wr(32'hFF1);
    wr(32'h0);
    chk("p5_full_hold", {31'd0, full_o}, 32'd1);
    chk("p5_f2_dropped", {31'd0, f2_empty_o}, 32'd1);
    pop(1, 32'h01, "p5_w0");
    chk("p5_full_clear", {31'd0, full_o}, 32'd0);
    for (int i = 1; i < 16; i++) pop(1, (32'(i) << 4) | 32'h1, $sformatf("p5_w%0d", i));
    chk("p5_f1_drained", {31'd0, f1_empty_o}, 32'd1);

    // reset mid-packet: cmd 0x7 (N=4) plus one payload word, then reset
    wr(32'h7); wr(32'h55);
    rst_ni = 1'b0;
    #2;
    chk("p6_rst_f1_empty", {31'd0, f1_empty_o}, 32'd1);
    chk("p6_rst_f2_empty", {31'd0, f2_empty_o}, 32'd1);
    chk("p6_rst_full", {31'd0, full_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    // 0x2: FIFO2, f=1 -> one payload word
    wr(32'h2); wr(32'h77);
    chk("p6_f1_empty", {31'd0, f1_empty_o}, 32'd1);
    pop(2, 32'h2,  "p6_cmd");
    pop(2, 32'h77, "p6_pl");
    chk("p6_f2_drained", {31'd0, f2_empty_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fifo_arb_rx.md
FIFO_ARB_RX -- requirements
Module: fifo_arb_rx

Interface
REQ-001 SHALL have parameter DW, default 32: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: entries per output FIFO; power of two, at least 2.
REQ-003 SHALL have parameter SEL_MASK [DW-1:0], default 1: route mask for command words.
REQ-004 SHALL have parameter CNT_SHIFT, default 1: bit position of the count field.
REQ-005 SHALL have parameter CNT_MASK, default 7: mask applied to the count field after shifting.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port wr_en_i, input, 1 bit: write strobe.
REQ-009 SHALL have port wr_data_i, input, DW bits: write word.
REQ-010 SHALL have port full_o, output, 1 bit: write back-pressure.
REQ-011 SHALL have ports f1_rd_en_i (input, 1 bit), f1_rd_data_o (output, DW bits) and f1_empty_o (output, 1 bit): output FIFO 1 read port.
REQ-012 SHALL have ports f2_rd_en_i (input, 1 bit), f2_rd_data_o (output, DW bits) and f2_empty_o (output, 1 bit): output FIFO 2 read port.

Function
REQ-013 SHALL treat the input stream as packets: one command word, then N payload words.
REQ-014 SHALL decode N as follows: f = (cmd >> CNT_SHIFT) & CNT_MASK; f=0->0, 1->1, 2->2, 3->4, 4->8, any other value->0.
REQ-015 SHALL route the whole packet (command word and all payload words) to FIFO 1 if (cmd & SEL_MASK) != 0, else to FIFO 2.
REQ-016 SHALL write command and payload words unmodified and in order into the selected FIFO; payload content SHALL NOT be decoded.
REQ-017 SHALL use a parser FSM with two states, CMD and DATA:
- CMD, accepted write with N=0: stay in CMD.
- CMD, accepted write with N>0: latch target and remaining=N, go to DATA.
- DATA, accepted write: decrement remaining; at remaining 1->0, return to CMD.
REQ-018 SHALL define an accepted write as wr_en_i=1 and full_o=0 on a rising edge; a write while full_o=1 SHALL be dropped with no state change.
REQ-019 SHALL drive full_o combinationally from state only, never from wr_data_i: in CMD, full_o = FIFO1 full OR FIFO2 full; in DATA, full_o = latched target FIFO full.
REQ-020 SHALL make each output FIFO DEPTH entries, first-word-fall-through: rd_data_o shows the head word whenever empty_o=0.
REQ-021 SHALL pop the head on a rising edge with rd_en_i=1 and empty_o=0; rd_en_i while empty SHALL be ignored, with no underflow.
REQ-022 SHALL make a written word visible at the FIFO output (empty_o=0) on the cycle after the accepting edge.
REQ-023 SHALL allow simultaneous push and pop on a full FIFO or a non-empty FIFO, keeping count unchanged and preserving order.
REQ-024 SHALL wrap read and write pointers modulo DEPTH, with one extra bit for full/empty discrimination.
REQ-025 SHALL run both read ports independently and concurrently with writes.

Reset
REQ-026 SHALL, on rst_ni=0 asynchronously, clear both FIFOs' pointers, set FSM to CMD, remaining=0, f1_empty_o=f2_empty_o=1, full_o=0.
REQ-027 SHALL discard any partially received packet on reset mid-packet; the first word after release SHALL be parsed as a command.
REQ-028 SHALL make FIFO storage contents don't-care after reset; rd_data_o while empty SHALL be don't-care.

Verification
REQ-029 SHALL verify: write 0x00000005, 0xA, 0xB -> FIFO1 yields 0x5, 0xA, 0xB; FIFO2 stays empty.
REQ-030 SHALL verify: write 0x00000000, then 0x00000006 -> FIFO2 yields 0x0 then 0x6 (N=0 and N=4) with the next four words also on FIFO2; FIFO1 empty.
REQ-031 SHALL verify: write 0x00000009 followed by 8 payload words -> all 9 words on FIFO1 in order; next word treated as a command.
REQ-032 SHALL verify: write 0x0000000B (f=5) -> N=0, only the command word goes to FIFO1.
REQ-033 SHALL verify: FIFO1 filled to DEPTH with no reads -> full_o=1 in CMD; extra writes dropped; one f1 read -> full_o=0 next cycle; data intact.
REQ-034 SHALL verify: rst_ni pulsed low after 0x00000007 plus 1 payload word -> both empty, full_o=0; next word 0x00000002 routed to FIFO2 as a command.
